// File: rtl/pc_redirect_ctrl.sv
// PC update sequencer: arbitrates boot, redirect, stall and sequential PC loads,
// and keeps the last-branch PC and link register shadows.
module pc_redirect_ctrl #(
    parameter int unsigned FLUSH_CYCLES  = 2,
    parameter int unsigned WARMUP_CYCLES = 2,
    parameter int unsigned NSTALL        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              boot_req,
    input  logic [15:0]       boot_addr,
    input  logic [15:0]       fd_pc_next,
    input  logic              fd_branch,
    input  logic [15:0]       fd_fallback,
    input  logic              fd_bl,
    input  logic [15:0]       fd_ret_addr,
    input  logic              branch_fail,
    input  logic              link_back,
    input  logic [NSTALL-1:0] stall_in,
    output logic              pc_load,
    output logic [15:0]       pc_value,
    output logic [15:0]       lbpc,
    output logic [15:0]       lr,
    output logic              flush,
    output logic              decode_disable,
    output logic              stall_active,
    output logic [15:0]       redirect_cnt
);

    typedef enum logic [1:0] {StBoot, StWarmup, StRun, StFlush} state_e;

    localparam logic [1:0] WarmInit  = 2'(WARMUP_CYCLES - 1);
    localparam logic [2:0] FlushInit = 3'(FLUSH_CYCLES - 1);

    state_e      state_q;
    logic [1:0]  wcnt_q;
    logic [2:0]  fcnt_q;
    logic [15:0] lbpc_q;
    logic [15:0] lr_q;
    logic [15:0] redirect_cnt_q;

    logic redir_req;
    logic stall_req;
    logic live;
    logic do_redirect;
    logic do_stall;
    logic do_seq;

    assign redir_req   = branch_fail | link_back;
    assign stall_req   = |stall_in;
    assign live        = (state_q == StRun) || (state_q == StFlush);
    assign do_redirect = !boot_req && live && redir_req;
    assign do_stall    = !boot_req && (state_q == StRun) && !redir_req && stall_req;
    assign do_seq      = !boot_req && (state_q == StRun) && !redir_req && !stall_req;

    // Gated by rst_n so that the combinational load path stays quiet while reset is held.
    always_comb begin
        pc_load  = 1'b0;
        pc_value = 16'h0000;
        if (rst_n) begin
            if (boot_req) begin
                pc_load  = 1'b1;
                pc_value = boot_addr;
            end else if (do_redirect) begin
                pc_load  = 1'b1;
                pc_value = branch_fail ? lbpc_q : lr_q;
            end else if (do_seq) begin
                pc_load  = 1'b1;
                pc_value = fd_pc_next;
            end
        end
    end

    assign stall_active   = rst_n && do_stall;
    assign flush          = (state_q == StFlush);
    assign decode_disable = (state_q == StBoot) || (state_q == StWarmup);
    assign lbpc           = lbpc_q;
    assign lr             = lr_q;
    assign redirect_cnt   = redirect_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StBoot;
            wcnt_q         <= 2'd0;
            fcnt_q         <= 3'd0;
            lbpc_q         <= 16'h0000;
            lr_q           <= 16'h0000;
            redirect_cnt_q <= 16'h0000;
        end else if (boot_req) begin
            state_q <= StWarmup;
            wcnt_q  <= WarmInit;
        end else begin
            unique case (state_q)
                StBoot: ;
                StWarmup: begin
                    if (wcnt_q == 2'd0) state_q <= StRun;
                    else                wcnt_q  <= wcnt_q - 2'd1;
                end
                StRun: begin
                    if (redir_req) begin
                        state_q <= StFlush;
                        fcnt_q  <= FlushInit;
                        if (redirect_cnt_q != 16'hFFFF) redirect_cnt_q <= redirect_cnt_q + 16'd1;
                    end else if (!stall_req) begin
                        if (fd_branch) lbpc_q <= fd_fallback;
                        if (fd_bl)     lr_q   <= fd_ret_addr;
                    end
                end
                StFlush: begin
                    if (redir_req) begin
                        fcnt_q <= FlushInit;
                        if (redirect_cnt_q != 16'hFFFF) redirect_cnt_q <= redirect_cnt_q + 16'd1;
                    end else if (fcnt_q == 3'd0) begin
                        state_q <= StRun;
                    end else begin
                        fcnt_q <= fcnt_q - 3'd1;
                    end
                end
                default: state_q <= StBoot;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: a cycle model queues the expected outputs for each
// driven cycle and they are compared on the falling edge.
module tb_pc_redirect_ctrl;

    localparam int unsigned FlushCycles  = 2;
    localparam int unsigned WarmupCycles = 2;
    localparam int unsigned NStall       = 8;

    localparam int MBoot = 0, MWarm = 1, MRun = 2, MFlush = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              boot_req = 1'b0;
    logic [15:0]       boot_addr = 16'h0;
    logic [15:0]       fd_pc_next = 16'h0;
    logic              fd_branch = 1'b0;
    logic [15:0]       fd_fallback = 16'h0;
    logic              fd_bl = 1'b0;
    logic [15:0]       fd_ret_addr = 16'h0;
    logic              branch_fail = 1'b0;
    logic              link_back = 1'b0;
    logic [NStall-1:0] stall_in = '0;
    logic              pc_load;
    logic [15:0]       pc_value;
    logic [15:0]       lbpc;
    logic [15:0]       lr;
    logic              flush;
    logic              decode_disable;
    logic              stall_active;
    logic [15:0]       redirect_cnt;

    pc_redirect_ctrl #(
        .FLUSH_CYCLES (FlushCycles),
        .WARMUP_CYCLES(WarmupCycles),
        .NSTALL       (NStall)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .boot_req      (boot_req),
        .boot_addr     (boot_addr),
        .fd_pc_next    (fd_pc_next),
        .fd_branch     (fd_branch),
        .fd_fallback   (fd_fallback),
        .fd_bl         (fd_bl),
        .fd_ret_addr   (fd_ret_addr),
        .branch_fail   (branch_fail),
        .link_back     (link_back),
        .stall_in      (stall_in),
        .pc_load       (pc_load),
        .pc_value      (pc_value),
        .lbpc          (lbpc),
        .lr            (lr),
        .flush         (flush),
        .decode_disable(decode_disable),
        .stall_active  (stall_active),
        .redirect_cnt  (redirect_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        pc_load;
        logic [15:0] pc_value;
        logic [15:0] lbpc;
        logic [15:0] lr;
        logic        flush;
        logic        decode_disable;
        logic        stall_active;
        logic [15:0] redirect_cnt;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int flush_seen = 0;

    int          m_state;
    int          m_wcnt;
    int          m_fcnt;
    logic [15:0] m_lbpc;
    logic [15:0] m_lr;
    logic [15:0] m_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_state = MBoot;
        m_wcnt  = 0;
        m_fcnt  = 0;
        m_lbpc  = 16'h0;
        m_lr    = 16'h0;
        m_cnt   = 16'h0;
    endtask

    function automatic exp_t model_expect();
        exp_t e;
        logic redir;
        redir            = branch_fail || link_back;
        e.pc_load        = 1'b0;
        e.pc_value       = 16'h0;
        e.stall_active   = 1'b0;
        e.lbpc           = m_lbpc;
        e.lr             = m_lr;
        e.redirect_cnt   = m_cnt;
        e.flush          = (m_state == MFlush);
        e.decode_disable = (m_state == MBoot) || (m_state == MWarm);
        if (boot_req) begin
            e.pc_load  = 1'b1;
            e.pc_value = boot_addr;
        end else if ((m_state == MRun || m_state == MFlush) && redir) begin
            e.pc_load  = 1'b1;
            e.pc_value = branch_fail ? m_lbpc : m_lr;
        end else if (m_state == MRun && stall_in != '0) begin
            e.stall_active = 1'b1;
        end else if (m_state == MRun) begin
            e.pc_load  = 1'b1;
            e.pc_value = fd_pc_next;
        end
        return e;
    endfunction

    task automatic model_update();
        logic redir;
        redir = branch_fail || link_back;
        if (boot_req) begin
            m_state = MWarm;
            m_wcnt  = WarmupCycles - 1;
        end else if (m_state == MWarm) begin
            if (m_wcnt == 0) m_state = MRun;
            else             m_wcnt--;
        end else if (m_state == MRun || m_state == MFlush) begin
            if (redir) begin
                m_state = MFlush;
                m_fcnt  = FlushCycles - 1;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end else if (m_state == MFlush) begin
                if (m_fcnt == 0) m_state = MRun;
                else             m_fcnt--;
            end else if (stall_in == '0) begin
                if (fd_branch) m_lbpc = fd_fallback;
                if (fd_bl)     m_lr   = fd_ret_addr;
            end
        end
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic step();
        exp_t e;
        exp_t got;
        exp_q.push_back(model_expect());
        @(negedge clk);
        e   = exp_q.pop_front();
        got = '{pc_load, pc_value, lbpc, lr, flush, decode_disable, stall_active, redirect_cnt};
        if (flush) flush_seen++;
        check_eq("pc_load", 32'(got.pc_load), 32'(e.pc_load));
        check_eq("pc_value", 32'(got.pc_value), 32'(e.pc_value));
        check_eq("lbpc", 32'(got.lbpc), 32'(e.lbpc));
        check_eq("lr", 32'(got.lr), 32'(e.lr));
        check_eq("flush", 32'(got.flush), 32'(e.flush));
        check_eq("decode_disable", 32'(got.decode_disable), 32'(e.decode_disable));
        check_eq("stall_active", 32'(got.stall_active), 32'(e.stall_active));
        check_eq("redirect_cnt", 32'(got.redirect_cnt), 32'(e.redirect_cnt));
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic boot_to_run(input logic [15:0] addr);
        boot_req  = 1'b1;
        boot_addr = addr;
        step();
        boot_req = 1'b0;
        repeat (WarmupCycles) step();
    endtask

    initial begin
        model_reset();
        // Reset held with boot_req high: combinational load must stay off.
        boot_req = 1'b1;
        #12;
        check_eq("rst_pc_load", 32'(pc_load), 32'h0);
        check_eq("rst_pc_value", 32'(pc_value), 32'h0);
        check_eq("rst_flush", 32'(flush), 32'h0);
        check_eq("rst_decode_disable", 32'(decode_disable), 32'h1);
        check_eq("rst_stall_active", 32'(stall_active), 32'h0);
        check_eq("rst_lbpc", 32'(lbpc), 32'h0);
        check_eq("rst_lr", 32'(lr), 32'h0);
        check_eq("rst_redirect_cnt", 32'(redirect_cnt), 32'h0);
        boot_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: boot, two warm-up cycles, then sequential fetch
        step();
        boot_to_run(16'h0100);
        check_eq("warmup_done", 32'(decode_disable), 32'h0);
        fd_pc_next = 16'h0102;
        step();

        // 2: branch capture then branch_fail revert
        fd_branch = 1'b1; fd_fallback = 16'h0200; fd_pc_next = 16'h0340;
        step();
        check_eq("lbpc_capture", 32'(lbpc), 32'h0200);
        fd_branch = 1'b0; branch_fail = 1'b1;
        step();
        branch_fail = 1'b0;
        check_eq("cnt_after_bf", 32'(redirect_cnt), 32'h1);
        check_eq("flush_after_bf", 32'(flush), 32'h1);
        flush_seen = 0;
        repeat (3) step();
        check_eq("flush_len", 32'(flush_seen), 32'd2);

        // 3: BL capture, then branch_fail beats link_back
        fd_bl = 1'b1; fd_ret_addr = 16'h0452; fd_pc_next = 16'h0800;
        step();
        fd_bl = 1'b0; fd_branch = 1'b1; fd_fallback = 16'h0600; fd_pc_next = 16'h0802;
        step();
        fd_branch = 1'b0; branch_fail = 1'b1; link_back = 1'b1;
        fd_bl = 1'b1; fd_ret_addr = 16'h0BAD;
        step();
        branch_fail = 1'b0; link_back = 1'b0; fd_bl = 1'b0;
        check_eq("lr_kept", 32'(lr), 32'h0452);
        check_eq("lbpc_kept", 32'(lbpc), 32'h0600);
        repeat (3) step();

        // 4: stall for three cycles, branch capture suppressed
        stall_in = 8'h10; fd_branch = 1'b1; fd_fallback = 16'h0999;
        repeat (3) step();
        check_eq("lbpc_stall", 32'(lbpc), 32'h0600);
        stall_in = '0; fd_branch = 1'b0;
        step();

        // 5: link_back during the first FLUSH cycle re-redirects to LR
        branch_fail = 1'b1;
        step();
        branch_fail = 1'b0; link_back = 1'b1;
        flush_seen = 0;
        step();
        link_back = 1'b0;
        repeat (3) step();
        check_eq("flush_extended", 32'(flush_seen), 32'd3);
        check_eq("cnt_after_lb", 32'(redirect_cnt), 32'h4);

        // 6: asynchronous reset in the middle of FLUSH
        branch_fail = 1'b1;
        step();
        branch_fail = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("arst_flush", 32'(flush), 32'h0);
        check_eq("arst_decode_disable", 32'(decode_disable), 32'h1);
        check_eq("arst_lbpc", 32'(lbpc), 32'h0);
        check_eq("arst_lr", 32'(lr), 32'h0);
        check_eq("arst_cnt", 32'(redirect_cnt), 32'h0);
        check_eq("arst_pc_load", 32'(pc_load), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Saturation: a held branch_fail redirects every cycle in RUN/FLUSH
        boot_to_run(16'h0010);
        branch_fail = 1'b1;
        repeat (65535) step();
        check_eq("cnt_at_max", 32'(redirect_cnt), 32'hFFFF);
        step();
        check_eq("cnt_saturated", 32'(redirect_cnt), 32'hFFFF);
        branch_fail = 1'b0;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
